elastic_pipereg: RTL and testbench

Parametrised elastic pipeline register: a DEPTH-entry valid/ready buffer that replaces the fixed flush/stall stage register between pipeline stages. Unlike the single-entry stage register it does not lose throughput under back-pressure. Upstream sees a registered `in_ready`, with no combinational path from `out_ready`. It keeps the global `all_ready` advance gate, flush and stall, and exposes an occupancy count for the hazard unit.

---
 rtl/elastic_pipereg_pkg.sv | 17 +
 rtl/elastic_pipereg_ring_ptr.sv | 28 ++
 rtl/elastic_pipereg.sv | 92 +++++++++
 tb/tb_elastic_pipereg.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/elastic_pipereg_pkg.sv
// Shared types and helpers for the elastic pipeline register.
// The event encoding names the four ways a cycle can move the buffer.
package elastic_pipereg_pkg;

   typedef enum logic [1:0] {
      EV_IDLE = 2'b00,
      EV_POP  = 2'b01,
      EV_PUSH = 2'b10,
      EV_BOTH = 2'b11
   } ev_e;

   // Pointer width for a ring of the given depth (at least one bit).
   function automatic int unsigned ptr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/elastic_pipereg_ring_ptr.sv
// Wrapping ring pointer: counts 0..DEPTH-1 and wraps to 0, with a
// synchronous clear that overrides the increment.
module ring_ptr
   import elastic_pipereg_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      clr,
   input  logic                      inc,
   output logic [ptr_w(DEPTH)-1:0]   ptr
);

   localparam int PW = ptr_w(DEPTH);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr <= '0;
      end else if (clr) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= (ptr == LAST) ? '0 : ptr + PW'(1);
      end
   end

endmodule

// File: rtl/elastic_pipereg.sv
// DEPTH-entry valid/ready circular buffer between pipeline stages with
// flush, stall, global advance gate and an occupancy count.
module elastic_pipereg
   import elastic_pipereg_pkg::*;
#(
   parameter type T     = logic,
   parameter T    INIT  = '0,
   parameter int  DEPTH = 2
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        in_valid,
   input  T                            in_data,
   output logic                        in_ready,
   output logic                        out_valid,
   output T                            out_data,
   input  logic                        out_ready,
   input  logic                        flush,
   input  logic                        stall,
   input  logic                        all_ready,
   output logic [$clog2(DEPTH+1)-1:0]  count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = ptr_w(DEPTH);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   if (DEPTH < 2) begin : g_depth_chk
      $error("elastic_pipereg: DEPTH must be at least 2");
   end

   T              mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic          push;
   logic          pop;
   logic          flush_go;
   ev_e           ev;

   // in_ready depends only on registered count, never on out_ready.
   assign in_ready  = reset_n && all_ready && (count != FULL);
   assign out_valid = all_ready && !flush && !stall && (count != '0);
   assign out_data  = (count != '0) ? mem[rd_ptr] : INIT;

   assign push     = in_valid && in_ready && !flush;
   assign pop      = out_valid && out_ready;
   assign flush_go = flush && all_ready;

   always_comb begin
      ev = EV_IDLE;
      unique case ({push, pop})
         2'b10:   ev = EV_PUSH;
         2'b01:   ev = EV_POP;
         2'b11:   ev = EV_BOTH;
         default: ev = EV_IDLE;
      endcase
   end

   ring_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (flush_go),
      .inc     (pop),
      .ptr     (rd_ptr)
   );

   ring_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (flush_go),
      .inc     (push),
      .ptr     (wr_ptr)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= INIT;
         count <= '0;
      end else if (flush_go) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= INIT;
         count <= '0;
      end else begin
         if (push) mem[wr_ptr] <= in_data;
         unique case (ev)
            EV_PUSH: count <= count + CW'(1);
            EV_POP:  count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_elastic_pipereg.sv
// Bench for elastic_pipereg: directed vector table, streaming, async reset,
// and randomized traffic against a queue-based reference model.
module tb_elastic_pipereg;

   typedef logic [7:0] byte_t;
   localparam byte_t INIT_V = 8'hEE;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic       iv3 = 0, or3 = 0, fl3 = 0, st3 = 0, ar3 = 1;
   byte_t      d3 = '0;
   logic       ir3, ov3;
   byte_t      od3;
   logic [1:0] cnt3;

   logic       iv2 = 0, or2 = 0, fl2 = 0, st2 = 0, ar2 = 1;
   byte_t      d2 = '0;
   logic       ir2, ov2;
   byte_t      od2;
   logic [1:0] cnt2;

   elastic_pipereg #(.T(byte_t), .INIT(INIT_V), .DEPTH(3)) dut3 (
      .clk(clk), .reset_n(reset_n), .in_valid(iv3), .in_data(d3),
      .in_ready(ir3), .out_valid(ov3), .out_data(od3), .out_ready(or3),
      .flush(fl3), .stall(st3), .all_ready(ar3), .count(cnt3));

   elastic_pipereg #(.T(byte_t), .INIT(INIT_V), .DEPTH(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .in_valid(iv2), .in_data(d2),
      .in_ready(ir2), .out_valid(ov2), .out_data(od2), .out_ready(or2),
      .flush(fl2), .stall(st2), .all_ready(ar2), .count(cnt2));

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk3(input string nm, input int c, input logic eir, input logic eov,
                       input byte_t eod);
      chk({nm, " count"},     32'(cnt3), 32'(c));
      chk({nm, " in_ready"},  32'(ir3),  32'(eir));
      chk({nm, " out_valid"}, 32'(ov3),  32'(eov));
      chk({nm, " out_data"},  32'(od3),  32'(eod));
   endtask

   typedef struct {
      logic  iv;
      byte_t d;
      logic  ordy, fl, st, ar;
      int    cnt;
      logic  ir, ov;
      byte_t od;
   } vec_t;

   vec_t vt [18];

   // Outputs in each vector are the values seen before that cycle's edge.
   initial begin
      //            iv  d      ordy fl st ar  cnt ir ov od
      vt[0]  = '{1, 8'h0A, 0, 0, 0, 1, 0, 1, 0, INIT_V};
      vt[1]  = '{1, 8'h0B, 0, 0, 0, 1, 1, 1, 1, 8'h0A};
      vt[2]  = '{1, 8'h0C, 0, 0, 0, 1, 2, 1, 1, 8'h0A};
      vt[3]  = '{1, 8'h0D, 0, 0, 0, 1, 3, 0, 1, 8'h0A};
      vt[4]  = '{0, 8'h00, 1, 0, 0, 1, 3, 0, 1, 8'h0A};
      vt[5]  = '{0, 8'h00, 0, 0, 0, 1, 2, 1, 1, 8'h0B};
      vt[6]  = '{1, 8'h05, 1, 1, 1, 1, 2, 1, 0, 8'h0B};
      vt[7]  = '{0, 8'h00, 1, 0, 0, 1, 0, 1, 0, INIT_V};
      vt[8]  = '{1, 8'h07, 0, 0, 0, 1, 0, 1, 0, INIT_V};
      vt[9]  = '{1, 8'h09, 1, 1, 0, 0, 1, 0, 0, 8'h07};
      vt[10] = '{1, 8'h09, 1, 1, 0, 0, 1, 0, 0, 8'h07};
      vt[11] = '{1, 8'h09, 1, 1, 0, 0, 1, 0, 0, 8'h07};
      vt[12] = '{1, 8'h09, 1, 1, 0, 1, 1, 1, 0, 8'h07};
      vt[13] = '{0, 8'h00, 1, 0, 0, 1, 0, 1, 0, INIT_V};
      vt[14] = '{1, 8'h03, 0, 0, 0, 1, 0, 1, 0, INIT_V};
      vt[15] = '{0, 8'h00, 1, 0, 1, 1, 1, 1, 0, 8'h03};
      vt[16] = '{0, 8'h00, 1, 0, 0, 1, 1, 1, 1, 8'h03};
      vt[17] = '{0, 8'h00, 0, 0, 0, 1, 0, 1, 0, INIT_V};
   end

   byte_t q [$];
   int    emitted5;

   initial begin
      // Reset state
      #2;
      chk3("reset", 0, 0, 0, INIT_V);
      chk("reset dut2 in_ready", 32'(ir2), 32'(0));
      #10 reset_n = 1'b1;
      @(posedge clk); #1;

      // Directed vector table on DEPTH=3
      for (int i = 0; i < 18; i++) begin
         iv3 = vt[i].iv; d3 = vt[i].d; or3 = vt[i].ordy;
         fl3 = vt[i].fl; st3 = vt[i].st; ar3 = vt[i].ar;
         @(negedge clk);
         chk3($sformatf("vec%0d", i), vt[i].cnt, vt[i].ir, vt[i].ov, vt[i].od);
         if (vt[i].ov && vt[i].ordy && vt[i].od == 8'h05) chk("flushed 0x5 leaked", 1, 0);
         @(posedge clk); #1;
      end
      iv3 = 0; or3 = 0; fl3 = 0; st3 = 0; ar3 = 1;

      // Streaming on DEPTH=2: data 1..8, one cycle late, count steady at 1
      or2 = 1;
      for (int k = 0; k <= 8; k++) begin
         iv2 = (k < 8); d2 = byte_t'(k + 1);
         @(negedge clk);
         chk($sformatf("stream%0d count", k), 32'(cnt2), 32'((k == 0) ? 0 : 1));
         chk($sformatf("stream%0d out_valid", k), 32'(ov2), 32'(k > 0));
         chk($sformatf("stream%0d in_ready", k), 32'(ir2), 32'(1));
         if (k > 0) chk($sformatf("stream%0d out_data", k), 32'(od2), 32'(k));
         @(posedge clk); #1;
      end
      iv2 = 0; or2 = 0;

      // Async reset mid-cycle with count=2
      iv3 = 1; d3 = 8'h21; @(posedge clk); #1;
      d3 = 8'h22;          @(posedge clk); #1;
      iv3 = 0; or3 = 1;
      @(negedge clk);
      chk3("pre-reset", 2, 1, 1, 8'h21);
      #1 reset_n = 1'b0;
      #1;
      chk3("in-reset", 0, 0, 0, INIT_V);
      #6 reset_n = 1'b1;
      @(negedge clk);
      chk3("post-reset", 0, 1, 0, INIT_V);
      @(posedge clk); #1;

      // Randomized traffic against a queue model
      q.delete();
      emitted5 = 0;
      for (int n = 0; n < 600; n++) begin
         int    sz;
         logic  e_ir, e_ov;
         byte_t e_od;
         iv3 = ($urandom_range(0, 2) != 0);
         d3  = byte_t'($urandom);
         or3 = ($urandom_range(0, 2) != 0);
         fl3 = ($urandom_range(0, 19) == 0);
         st3 = ($urandom_range(0, 7) == 0);
         ar3 = ($urandom_range(0, 9) != 0);
         @(negedge clk);
         sz   = q.size();
         e_ir = ar3 && (sz < 3);
         e_ov = ar3 && !fl3 && !st3 && (sz > 0);
         e_od = (sz > 0) ? q[0] : INIT_V;
         chk3($sformatf("rand%0d", n), sz, e_ir, e_ov, e_od);
         if (ar3 && fl3) begin
            q.delete();
         end else begin
            if (e_ov && or3) void'(q.pop_front());
            if (iv3 && e_ir) q.push_back(d3);
         end
         @(posedge clk); #1;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
